// File: rtl/uart_defs.sv
// Shared UART definitions: receiver FSM state encoding and default bit timing.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state for 8E1).
package uart_defs;

  // 115200 baud from a 50 MHz clock.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY    = 3'd5
`endif
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset high.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    // NOTE: reset to the idle level (high) so leaving reset never looks like a start bit.
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so both flops sample the pre-edge values.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling with a single bit-period counter.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with even-parity check).
module uart_rx
  import uart_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_prev_q;
  logic             rx_sync;
  logic             byte_good;
  logic             frame_bad;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_sync)
  );

  // Next-state logic: frame sequencing, sampling and the consumer-facing flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_good = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (rx_prev_q && !rx_sync) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_sync) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          par_err_d = rx_sync ^ (^shift_q);
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            byte_good = !par_err_q;
            frame_bad = par_err_q;
`else
            byte_good = 1'b1;
`endif
          end else begin
            frame_bad = 1'b1;
            state_d   = ST_WAIT_HIGH;  // line held low: wait out the break
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new byte wins over an acknowledge landing in the same cycle.
    data_d      = byte_good ? shift_q : data_q;
    valid_d     = byte_good ? 1'b1 : (rx_ack ? 1'b0 : valid_q);
    overrun_d   = (byte_good && valid_q && !rx_ack) ? 1'b1
                : (rx_ack ? 1'b0 : overrun_q);
    frame_err_d = frame_bad ? 1'b1 : (rx_ack ? 1'b0 : frame_err_q);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_prev_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_prev_q   <= rx_sync;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLKS_PER_BIT=16; expected bytes are
// queued when a frame is sent and popped when the receiver reports a byte.
// Honours UART_RX_PARITY_EN for 8E1 framing.
module tb_uart_rx;
  import uart_defs::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_ovr = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  // One frame: start, 8 data LSB first, [even parity ^ par_flip], stop_v.
  // The line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    tick(CPB);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    rx = stop_v;
    tick(CPB);
  endtask

  // Scoreboard: a byte is reported when rx_valid rises or an overrun is flagged.
  always @(negedge clk) begin
    if (!rst && ((rx_valid && !prev_valid) || (rx_overrun && !prev_ovr))) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_data", rx_data, exp_q.pop_front());
    end
    prev_valid <= rx_valid;
    prev_ovr   <= rx_overrun;
  end

  initial begin
    tick(3);
    rst = 1'b0;
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ovr", rx_overrun, 1'b0);
    check("rst_ferr", rx_frame_err, 1'b0);
    tick(4);

    // Single byte with exact latency from the falling edge.
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        tick(154);
        check("lat_before", rx_valid, 1'b0);
        tick(1);
        check("lat_at", rx_valid, 1'b1);
        check("lat_data", rx_data, 8'hA5);
      end
    join
    check("a5_ovr", rx_overrun, 1'b0);
    check("a5_ferr", rx_frame_err, 1'b0);

    // Overrun: second byte while the first is unacknowledged.
    ack_pulse();
    check("ack_valid", rx_valid, 1'b0);
    tick(4);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(4);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    check("ovr_data", rx_data, 8'hC3);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_flag", rx_overrun, 1'b1);
    ack_pulse();
    check("ovr_ack_valid", rx_valid, 1'b0);
    check("ovr_ack_ovr", rx_overrun, 1'b0);
    check("ovr_ack_ferr", rx_frame_err, 1'b0);

    // Byte completing in the same cycle as an acknowledge.
    tick(4);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(4);
    fork
      send_frame(8'h96, 1'b1, 1'b0);
      begin
        tick(154);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        check("same_valid", rx_valid, 1'b1);
        check("same_ovr", rx_overrun, 1'b0);
        check("same_data", rx_data, 8'h96);
      end
    join
    ack_pulse();

    // Bad stop bit followed by a long break.
    tick(4);
    send_frame(8'h55, 1'b0, 1'b0);
    tick(40 * CPB);
    check("brk_ferr", rx_frame_err, 1'b1);
    check("brk_valid", rx_valid, 1'b0);
    check("brk_state", dut.state_q, ST_WAIT_HIGH);
    check("brk_data", rx_data, 8'h96);
    rx = 1'b1;
    tick(2 * CPB);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    check("brk_next_data", rx_data, 8'h01);
    check("brk_ferr_sticky", rx_frame_err, 1'b1);
    ack_pulse();

    // Short low glitch.
    tick(4);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * CPB);
    check("gl_valid", rx_valid, 1'b0);
    check("gl_ferr", rx_frame_err, 1'b0);
    check("gl_ovr", rx_overrun, 1'b0);
    check("gl_state", dut.state_q, ST_IDLE);

    // Reset in the middle of data bit 3 of 0xFF.
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB + CPB / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_state", dut.state_q, ST_IDLE);
    tick(8 * CPB);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    check("post_rst_data", rx_data, 8'h12);
    check("post_rst_ovr", rx_overrun, 1'b0);
    check("post_rst_ferr", rx_frame_err, 1'b0);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    // Parity error then a correct resend of 0x07.
    tick(4);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(2);
    check("par_ferr", rx_frame_err, 1'b1);
    check("par_valid", rx_valid, 1'b0);
    ack_pulse();
    tick(4);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_ok_data", rx_data, 8'h07);
    check("par_ok_ferr", rx_frame_err, 1'b0);
`endif

    tick(4);
    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL give the clk cycles per serial bit; legal range is 4..65535.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: SHALL be the reset; synchronous, active-high.
REQ-004 Port rx, input, 1: SHALL be the asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 Port rx_ack, input, 1: SHALL be a one-cycle pulse meaning the consumer has taken rx_data.
REQ-006 Port rx_data, output, 8: SHALL hold the last received byte.
REQ-007 Port rx_valid, output, 1: SHALL be high while rx_data holds an unacknowledged byte.
REQ-008 Port rx_overrun, output, 1: SHALL be a sticky flag meaning a byte completed while rx_valid was high.
REQ-009 Port rx_frame_err, output, 1: SHALL be a sticky flag meaning a bad stop bit (or bad parity, per REQ-024) was detected.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH; PARITY is added per REQ-024.
- IDLE -> START on a synchronized high-to-low transition.
REQ-012 START SHALL count CLKS_PER_BIT/2 cycles (integer division) and then sample.
- Low -> DATA, bit counter = 0.
- High -> IDLE as a glitch, with no flag change.
REQ-013 DATA SHALL sample once every CLKS_PER_BIT cycles.
- Each sample shifts in LSB first.
- After the 8th sample -> STOP.
REQ-014 STOP SHALL sample once after CLKS_PER_BIT cycles.
- High: load rx_data and set rx_valid the following cycle -> IDLE.
- Low: set rx_frame_err, discard the byte, leave rx_data and rx_valid unchanged -> WAIT_HIGH.
REQ-015 WAIT_HIGH SHALL remain until synchronized rx is high, then -> IDLE, so a break does not retrigger reception.
REQ-016 rx_ack SHALL clear rx_valid, rx_overrun and rx_frame_err on the next cycle; rx_ack while rx_valid is low SHALL only clear the flags.
REQ-017 A good byte completing while rx_valid is high and rx_ack is low SHALL overwrite rx_data, keep rx_valid high and set rx_overrun.
REQ-018 A good byte completing in the same cycle as rx_ack SHALL load rx_data, keep rx_valid high, leave rx_overrun clear and clear rx_frame_err.
REQ-019 The bit-period counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide and reload to 0 at every sample point, with no wrap-around drift.
REQ-020 Latency: rx_valid SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the falling edge on rx.

Reset
REQ-021 rst SHALL force the FSM to IDLE and clear the counters, the shift register, rx_data (0x00), rx_valid, rx_overrun and rx_frame_err.
REQ-022 The synchronizer flops SHALL reset to 1.
REQ-023 rst mid-frame SHALL abort the frame; reception restarts only on a new falling edge.

Configuration
REQ-024 With UART_RX_PARITY_EN defined, the frame SHALL be 8E1.
- State PARITY is inserted between DATA and STOP and sampled once.
- A parity mismatch SHALL set rx_frame_err and discard the byte; the FSM still checks the stop bit.
- REQ-020 latency grows by CLKS_PER_BIT.
- Without the macro the frame SHALL be 8N1 and no parity logic SHALL exist.

Structure
REQ-025 The FSM state encoding and the default CLKS_PER_BIT SHALL live in the shared uart_defs package/include used by uarttx.
REQ-026 The synchronizer SHALL be the sub-module uart_sync2 (1-bit, reset value 1).

Verification (bench uses CLKS_PER_BIT=16)
REQ-027 Send 0xA5, no ack -> rx_data=0xA5 and rx_valid=1 exactly 155 cycles after the rx falling edge; both flags 0.
REQ-028 Send 0x3C, no ack, then send 0xC3 -> rx_data=0xC3, rx_valid=1, rx_overrun=1; pulse rx_ack -> all three outputs 0 next cycle.
REQ-029 Send 0x55 with the stop bit forced low, then hold rx low for 40 bit periods -> rx_frame_err=1, rx_valid=0, FSM held in WAIT_HIGH; release rx high, then send 0x01 -> rx_data=0x01.
REQ-030 Drive rx low for 4 cycles only -> no flag change, FSM back in IDLE.
REQ-031 Assert rst during data bit 3 of 0xFF, then send 0x12 -> rx_data=0x12 with no flags set.
REQ-032 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> rx_frame_err=1 and rx_valid=0; resend with parity bit 1 -> rx_data=0x07.
